tpx3_status_led: RTL and testbench

TPX3_STATUS_LED -- requirements
Module: tpx3_status_led

---
 rtl/tpx3_status_pkg.sv | 22 ++
 rtl/tpx3_ready_debounce.sv | 48 ++++
 rtl/tpx3_status_led.sv | 144 ++++++++++++++
 tb/tb_tpx3_status_led.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/tpx3_status_pkg.sv
// Shared types and sizing helpers for the Timepix3 status LED block.
// Holds the blink FSM state encoding and the counter width helpers.
package tpx3_status_pkg;

    typedef enum logic [1:0] {
        ST_GAP = 2'd0,
        ST_ON  = 2'd1,
        ST_OFF = 2'd2
    } blink_state_t;

    // Bits needed to hold any value 0..n (used for popcount and remaining).
    function automatic int popcnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/tpx3_ready_debounce.sv
// Per-chip receiver-lock synchroniser with tick-based debounce on the rising side.
// Loss of lock drops the ready flag immediately; gaining lock needs a stable run of ticks.
module tpx3_ready_debounce
    import tpx3_status_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 3
)(
    input  logic BUS_CLK,
    input  logic BUS_RST_N,
    input  logic i_tick,
    input  logic i_rx_ready,
    output logic o_ready
);

    localparam int DW = popcnt_w(DEBOUNCE_TICKS);
    localparam logic [DW-1:0] LAST_CNT = DW'(DEBOUNCE_TICKS - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_ready;
    logic [DW-1:0] r_stable;

    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_ready  <= 1'b0;
            r_stable <= '0;
        end else begin
            r_sync1 <= i_rx_ready;
            r_sync2 <= r_sync1;
            if (!r_sync2) begin
                r_stable <= '0;
                r_ready  <= 1'b0;
            end else if (i_tick) begin
                // Counter saturates one short of the target; the final tick sets ready.
                if (r_stable == LAST_CNT) begin
                    r_ready <= 1'b1;
                end else begin
                    r_stable <= r_stable + DW'(1);
                end
            end
        end
    end

    assign o_ready = r_ready;

endmodule

// File: rtl/tpx3_status_led.sv
// Status LED driver: LED[0] mirrors Ethernet link, LED[1] blinks the number of locked chip links
// once per frame and is solid when every link is locked.
module tpx3_status_led
    import tpx3_status_pkg::*;
#(
    parameter int NUM_CHIPS      = 4,
    parameter int TICK_DIV       = 8000000,
    parameter int ON_TICKS       = 2,
    parameter int OFF_TICKS      = 2,
    parameter int GAP_TICKS      = 8,
    parameter int DEBOUNCE_TICKS = 3
)(
    input  logic                 BUS_CLK,
    input  logic                 BUS_RST_N,
    input  logic                 ETH_STATUS_OK,
    input  logic [NUM_CHIPS-1:0] RX_READY,
    output logic [1:0]           LED,
    output logic [NUM_CHIPS-1:0] READY_MASK,
    output logic                 ALL_READY
);

    localparam int CW = popcnt_w(NUM_CHIPS);
    localparam int PW = $clog2(TICK_DIV);
    localparam int TW = popcnt_w(max3(GAP_TICKS, ON_TICKS, OFF_TICKS));

    logic [PW-1:0]        r_presc;
    logic                 r_tick;
    logic                 r_eth_s1;
    logic                 r_eth_s2;
    logic                 r_led0;
    logic                 r_led1;
    logic                 r_all;
    logic [NUM_CHIPS-1:0] w_mask;
    logic [CW-1:0]        w_pop;

    blink_state_t  r_state, w_state_nxt;
    logic [TW-1:0] r_tcnt, w_tcnt_nxt;
    logic [CW-1:0] r_rem, w_rem_nxt;
    logic          r_solid, w_solid_nxt;

    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            r_presc  <= '0;
            r_tick   <= 1'b0;
            r_eth_s1 <= 1'b0;
            r_eth_s2 <= 1'b0;
            r_led0   <= 1'b0;
            r_all    <= 1'b0;
        end else begin
            if (r_presc == PW'(TICK_DIV - 1)) begin
                r_presc <= '0;
                r_tick  <= 1'b1;
            end else begin
                r_presc <= r_presc + PW'(1);
                r_tick  <= 1'b0;
            end
            r_eth_s1 <= ETH_STATUS_OK;
            r_eth_s2 <= r_eth_s1;
            r_led0   <= r_eth_s2;
            r_all    <= &w_mask;
        end
    end

    for (genvar gi = 0; gi < NUM_CHIPS; gi++) begin : g_chip
        tpx3_ready_debounce #(
            .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
        ) u_deb (
            .BUS_CLK   (BUS_CLK),
            .BUS_RST_N (BUS_RST_N),
            .i_tick    (r_tick),
            .i_rx_ready(RX_READY[gi]),
            .o_ready   (w_mask[gi])
        );
    end

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < NUM_CHIPS; i++) begin
            w_pop = w_pop + CW'(w_mask[i]);
        end
    end

    // Blink sequencer: the chip count is latched only at the end of the gap, so
    // mask changes mid-frame never disturb the blinks already scheduled.
    always_comb begin
        w_state_nxt = r_state;
        w_tcnt_nxt  = r_tcnt;
        w_rem_nxt   = r_rem;
        w_solid_nxt = r_all ? r_solid : 1'b0;
        if (r_tick) begin
            w_tcnt_nxt = r_tcnt + TW'(1);
            case (r_state)
                ST_GAP: begin
                    if (r_tcnt == TW'(GAP_TICKS - 1)) begin
                        w_tcnt_nxt  = '0;
                        w_rem_nxt   = w_pop;
                        w_solid_nxt = (w_pop == CW'(NUM_CHIPS));
                        if (w_pop != '0) begin
                            w_state_nxt = ST_ON;
                        end
                    end
                end
                ST_ON: begin
                    if (r_tcnt == TW'(ON_TICKS - 1)) begin
                        w_tcnt_nxt  = '0;
                        w_rem_nxt   = r_rem - CW'(1);
                        w_state_nxt = ST_OFF;
                    end
                end
                ST_OFF: begin
                    if (r_tcnt == TW'(OFF_TICKS - 1)) begin
                        w_tcnt_nxt  = '0;
                        w_state_nxt = (r_rem == '0) ? ST_GAP : ST_ON;
                    end
                end
                default: begin
                    w_tcnt_nxt  = '0;
                    w_state_nxt = ST_GAP;
                end
            endcase
        end
    end

    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            r_state <= ST_GAP;
            r_tcnt  <= '0;
            r_rem   <= '0;
            r_solid <= 1'b0;
            r_led1  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tcnt  <= w_tcnt_nxt;
            r_rem   <= w_rem_nxt;
            r_solid <= w_solid_nxt;
            r_led1  <= (r_state == ST_ON) | r_solid;
        end
    end

    assign LED        = {r_led1, r_led0};
    assign READY_MASK = w_mask;
    assign ALL_READY  = r_all;

endmodule

// File: tb/tb_tpx3_status_led.sv
// Bench for tpx3_status_led: directed steps plus random segments, every cycle compared
// against a frame-position reference model.
module tb_tpx3_status_led;

    localparam int NC    = 4;
    localparam int TD    = 4;
    localparam int ONT   = 2;
    localparam int OFFT  = 2;
    localparam int GAPT  = 8;
    localparam int DEB   = 3;
    localparam int BLINK = ONT + OFFT;

    logic          BUS_CLK = 1'b0;
    logic          BUS_RST_N = 1'b0;
    logic          ETH_STATUS_OK = 1'b0;
    logic [NC-1:0] RX_READY = '0;
    logic [1:0]    LED;
    logic [NC-1:0] READY_MASK;
    logic          ALL_READY;

    tpx3_status_led #(
        .NUM_CHIPS(NC), .TICK_DIV(TD), .ON_TICKS(ONT),
        .OFF_TICKS(OFFT), .GAP_TICKS(GAPT), .DEBOUNCE_TICKS(DEB)
    ) dut (
        .BUS_CLK      (BUS_CLK),
        .BUS_RST_N    (BUS_RST_N),
        .ETH_STATUS_OK(ETH_STATUS_OK),
        .RX_READY     (RX_READY),
        .LED          (LED),
        .READY_MASK   (READY_MASK),
        .ALL_READY    (ALL_READY)
    );

    always #5 BUS_CLK = ~BUS_CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: clock edges since reset release, input history, per-chip
    // stable-tick counts, and the position (in ticks) inside the current frame.
    int            m_e;
    logic          m_eth_h[3];
    logic [NC-1:0] m_rx_h[3];
    int            m_cnt[NC];
    logic [NC-1:0] m_mask;
    logic          m_all, m_led0, m_led1, m_solid;
    int            m_p, m_n;

    function automatic int popc(input logic [NC-1:0] v);
        int c = 0;
        for (int i = 0; i < NC; i++) c += int'(v[i]);
        return c;
    endfunction

    task automatic model_reset();
        m_e = 0;
        for (int i = 0; i < 3; i++) begin
            m_eth_h[i] = 1'b0;
            m_rx_h[i]  = '0;
        end
        for (int i = 0; i < NC; i++) m_cnt[i] = 0;
        m_mask = '0; m_all = 1'b0; m_led0 = 1'b0; m_led1 = 1'b0; m_solid = 1'b0;
        m_p = 0; m_n = 0;
    endtask

    task automatic model_edge();
        logic [NC-1:0] mask_pre;
        logic all_pre, on_pre, tick, latched;
        m_e++;
        tick     = (m_e > 1) && (((m_e - 1) % TD) == 0);
        mask_pre = m_mask;
        all_pre  = m_all;
        on_pre   = (m_p >= GAPT) && (((m_p - GAPT) % BLINK) < ONT);
        m_led1   = on_pre | m_solid;
        m_all    = &mask_pre;
        m_eth_h[2] = m_eth_h[1]; m_eth_h[1] = m_eth_h[0]; m_eth_h[0] = ETH_STATUS_OK;
        m_led0   = m_eth_h[2];
        m_rx_h[2] = m_rx_h[1]; m_rx_h[1] = m_rx_h[0]; m_rx_h[0] = RX_READY;
        for (int i = 0; i < NC; i++) begin
            if (!m_rx_h[2][i]) begin
                m_cnt[i]  = 0;
                m_mask[i] = 1'b0;
            end else if (tick) begin
                if (m_cnt[i] < DEB) m_cnt[i]++;
                m_mask[i] = (m_cnt[i] >= DEB);
            end
        end
        latched = 1'b0;
        if (tick) begin
            m_p++;
            if (m_p == GAPT) begin
                latched = 1'b1;
                m_n     = popc(mask_pre);
                m_solid = (m_n == NC);
                if (m_n == 0) m_p = 0;
            end else if (m_p > GAPT && m_p == GAPT + m_n * BLINK) begin
                m_p = 0;
            end
        end
        if (!latched && !all_pre) m_solid = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s at edge %0d: got %0h expected %0h", tag, m_e, got, exp);
        end
    endtask

    task automatic step();
        @(posedge BUS_CLK);
        if (BUS_RST_N) model_edge();
        else model_reset();
        #1;
        chk("led", 32'(LED), 32'({m_led1, m_led0}));
        chk("ready_mask", 32'(READY_MASK), 32'(m_mask));
        chk("all_ready", 32'(ALL_READY), 32'(m_all));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    int   k, run, maxrun, idx, hold;
    logic seen;

    initial begin
        model_reset();
        steps(5);
        chk("reset_outputs", 32'({LED, READY_MASK, ALL_READY}), 32'd0);
        BUS_RST_N = 1'b1;
        steps(10);

        // Ethernet LED latency in both directions
        ETH_STATUS_OK = 1'b1;
        steps(2);
        chk("eth_rise_early", 32'(LED[0]), 32'd0);
        step();
        chk("eth_rise_3cyc", 32'(LED[0]), 32'd1);
        ETH_STATUS_OK = 1'b0;
        steps(2);
        chk("eth_fall_early", 32'(LED[0]), 32'd1);
        step();
        chk("eth_fall_3cyc", 32'(LED[0]), 32'd0);

        // Two chips ready: pulse width is ON_TICKS ticks
        RX_READY = 4'b0101;
        maxrun = 0; run = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            run = LED[1] ? run + 1 : 0;
            if (run > maxrun) maxrun = run;
        end
        chk("mask_0101", 32'(READY_MASK), 32'h5);
        chk("pulse_width", 32'(maxrun), 32'(ONT * TD));

        // All chips ready -> solid, then drop chip 2
        RX_READY = 4'b1111;
        steps(200);
        chk("all_ready_1111", 32'(ALL_READY), 32'd1);
        chk("led1_solid", 32'(LED[1]), 32'd1);
        RX_READY[2] = 1'b0;
        steps(2);
        chk("drop_before", 32'(READY_MASK), 32'hF);
        step();
        chk("drop_mask", 32'(READY_MASK), 32'hB);
        step();
        chk("drop_all_ready", 32'(ALL_READY), 32'd0);
        steps(40);

        // Short glitch on chip 0 must not be accepted
        RX_READY = '0;
        steps(150);
        RX_READY[0] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8 * 1 + 100; i++) begin
            if (i == 2 * TD) RX_READY[0] = 1'b0;
            step();
            seen |= READY_MASK[0] | LED[1];
        end
        chk("glitch_ignored", 32'(seen), 32'd0);

        // Reset during ON of a three-blink frame
        RX_READY = 4'b0111;
        k = 0;
        while (LED[1] !== 1'b1 && k < 500) begin step(); k++; end
        chk("wait_on_timeout", 32'(k < 500), 32'd1);
        steps(3);
        BUS_RST_N = 1'b0;
        model_reset();
        #1;
        chk("reset_async", 32'({LED, READY_MASK, ALL_READY}), 32'd0);
        steps(3);
        BUS_RST_N = 1'b1;
        k = 0;
        while (LED[1] !== 1'b1 && k < 200) begin step(); k++; end
        chk("first_pulse_timeout", 32'(k < 200), 32'd1);
        chk("first_pulse_after_gap", 32'(k >= GAPT * TD), 32'd1);

        // Mask grows from one chip to three during ON of a frame
        RX_READY = 4'b0001;
        steps(200);
        k = 0;
        while (LED[1] !== 1'b1 && k < 500) begin step(); k++; end
        chk("wait_on1_timeout", 32'(k < 500), 32'd1);
        RX_READY = 4'b0111;
        steps(300);

        // Random segments
        for (int s = 0; s < 40; s++) begin
            RX_READY      = NC'($urandom);
            ETH_STATUS_OK = 1'($urandom);
            hold          = int'($urandom_range(120, 1));
            for (int c = 0; c < hold; c++) begin
                if ($urandom_range(15, 0) == 0) begin
                    idx = int'($urandom_range(NC - 1, 0));
                    RX_READY[idx] = ~RX_READY[idx];
                end
                step();
            end
            if ($urandom_range(9, 0) == 0) begin
                BUS_RST_N = 1'b0;
                model_reset();
                steps(3);
                BUS_RST_N = 1'b1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
